issue_scoreboard: RTL

Issue-stage hazard tracker sitting directly upstream of the register manager. It holds one busy bit per integer and per float register for every destination issued to the misc/alu/mem/fpu units but not yet written back. It stalls the decoder while any source operand or the destination is still pending. It clears busy bits from the same four write-back ports that feed the register manager, so every operand read that is allowed through can be served from the register files or the write queue.

---
 rtl/issue_scoreboard_pkg.sv | 37 +++
 rtl/issue_scoreboard_if.sv | 55 +++++
 rtl/issue_scoreboard_busy_table.sv | 64 ++++++
 rtl/issue_scoreboard.sv | 125 ++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue-stage scoreboard and the register manager.
package issue_scoreboard_pkg;

    localparam int unsigned UNIT_MISC  = 0;
    localparam int unsigned UNIT_ALU   = 1;
    localparam int unsigned UNIT_MEM   = 2;
    localparam int unsigned UNIT_FPU   = 3;
    localparam int unsigned UNIT_COUNT = 4;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned VEC_CNT_W  = 6;   // 0..32 for one file
    localparam int unsigned BUSY_CNT_W = 7;   // 0..63 across both files

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_COUNT-1:0]  busy_vec_t;

    // Write-back port bundle, identical to the register manager's write inputs
    typedef struct packed {
        logic              enable;
        reg_addr_t         addr;
        logic [DATA_W-1:0] data;
        logic              is_float;
    } wb_port_t;

    // Number of set bits in one busy vector
    function automatic logic [VEC_CNT_W-1:0] popcount_vec(input busy_vec_t v);
        logic [VEC_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(REG_COUNT); i++) begin
            cnt = cnt + VEC_CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decoder / write-back bundle seen by the scoreboard.
interface issue_scoreboard_if #(
    parameter int unsigned STALL_CNT_W = 32
);
    import issue_scoreboard_pkg::*;

    logic             issue_valid;
    reg_addr_t        rs_addr;
    reg_addr_t        rt_addr;
    logic             rs_float;
    logic             rt_float;
    logic             rs_used;
    logic             rt_used;
    logic             dest_valid;
    reg_addr_t        dest_addr;
    logic             dest_float;

    logic             write_enable_misc;
    logic             write_enable_alu;
    logic             write_enable_mem;
    logic             write_enable_fpu;
    reg_addr_t        write_addr_misc;
    reg_addr_t        write_addr_alu;
    reg_addr_t        write_addr_mem;
    reg_addr_t        write_addr_fpu;
    logic             write_float_misc;
    logic             write_float_alu;
    logic             write_float_mem;
    logic             write_float_fpu;

    logic                     stall;
    logic                     issue_fire;
    logic [BUSY_CNT_W-1:0]    busy_count;
    logic                     idle;
    logic [STALL_CNT_W-1:0]   stall_cycles;

    modport master (
        output issue_valid, rs_addr, rt_addr, rs_float, rt_float, rs_used, rt_used,
               dest_valid, dest_addr, dest_float,
               write_enable_misc, write_enable_alu, write_enable_mem, write_enable_fpu,
               write_addr_misc, write_addr_alu, write_addr_mem, write_addr_fpu,
               write_float_misc, write_float_alu, write_float_mem, write_float_fpu,
        input  stall, issue_fire, busy_count, idle, stall_cycles
    );

    modport slave (
        input  issue_valid, rs_addr, rt_addr, rs_float, rt_float, rs_used, rt_used,
               dest_valid, dest_addr, dest_float,
               write_enable_misc, write_enable_alu, write_enable_mem, write_enable_fpu,
               write_addr_misc, write_addr_alu, write_addr_mem, write_addr_fpu,
               write_float_misc, write_float_alu, write_float_mem, write_float_fpu,
        output stall, issue_fire, busy_count, idle, stall_cycles
    );

endinterface

// File: rtl/issue_scoreboard_busy_table.sv
// One register file's busy vector: one set port, four clear ports, two read ports.
// Optional macro SCOREBOARD_BYPASS_EN: same-cycle clears mask the hazard view.
module issue_scoreboard_busy_table
    import issue_scoreboard_pkg::*;
#(
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        set_en_i,
    input  reg_addr_t                   set_addr_i,
    input  logic [UNIT_COUNT-1:0]       clr_en_i,
    input  reg_addr_t [UNIT_COUNT-1:0]  clr_addr_i,
    input  reg_addr_t                   rd_addr_a_i,
    input  reg_addr_t                   rd_addr_b_i,
    output logic                        rd_busy_a_o,
    output logic                        rd_busy_b_o,
    output busy_vec_t                   view_o,
    output busy_vec_t                   busy_d_o
);

    busy_vec_t busy_q;
    busy_vec_t busy_d;
    busy_vec_t clr_mask;
    busy_vec_t set_mask;
    busy_vec_t view;

    // Next state: clears first, then the set so a same-cycle set wins
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int p = 0; p < int'(UNIT_COUNT); p++) begin
            if (clr_en_i[p]) begin
                clr_mask[clr_addr_i[p]] = 1'b1;
            end
        end
        if (set_en_i && !(ZERO_R0 && (set_addr_i == '0))) begin
            set_mask[set_addr_i] = 1'b1;
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

`ifdef SCOREBOARD_BYPASS_EN
    // Write-backs in flight this cycle are already servable from the write queue
    assign view = busy_q & ~clr_mask;
`else
    assign view = busy_q;
`endif

    assign rd_busy_a_o = view[rd_addr_a_i];
    assign rd_busy_b_o = view[rd_addr_b_i];
    assign view_o      = view;
    assign busy_d_o    = busy_d;

    // Busy vector register; reset drops pending entries and same-cycle write-backs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard tracker: stalls the decoder on RAW/WAW against pending destinations.
// Optional macro SCOREBOARD_BYPASS_EN: same-cycle write-backs resolve hazards immediately.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    issue_scoreboard_if.slave  sb
);

    logic [UNIT_COUNT-1:0]      wb_en;
    logic [UNIT_COUNT-1:0]      wb_flt;
    reg_addr_t [UNIT_COUNT-1:0] wb_addr;
    logic [UNIT_COUNT-1:0]      int_clr_en;
    logic [UNIT_COUNT-1:0]      flt_clr_en;

    logic      int_rd_rs, int_rd_rt, flt_rd_rs, flt_rd_rt;
    busy_vec_t int_view, flt_view;
    busy_vec_t int_busy_d, flt_busy_d;

    logic rs_hazard, rt_hazard, dest_hazard;
    logic stall_c, fire_c;
    logic int_set_en, flt_set_en;

    logic [BUSY_CNT_W-1:0]  busy_count_d, busy_count_q;
    logic                   idle_d, idle_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // Gather the four write-back ports into indexed vectors
    always_comb begin
        wb_en              = '0;
        wb_flt             = '0;
        wb_addr            = '0;
        wb_en[UNIT_MISC]   = sb.write_enable_misc;
        wb_en[UNIT_ALU]    = sb.write_enable_alu;
        wb_en[UNIT_MEM]    = sb.write_enable_mem;
        wb_en[UNIT_FPU]    = sb.write_enable_fpu;
        wb_flt[UNIT_MISC]  = sb.write_float_misc;
        wb_flt[UNIT_ALU]   = sb.write_float_alu;
        wb_flt[UNIT_MEM]   = sb.write_float_mem;
        wb_flt[UNIT_FPU]   = sb.write_float_fpu;
        wb_addr[UNIT_MISC] = sb.write_addr_misc;
        wb_addr[UNIT_ALU]  = sb.write_addr_alu;
        wb_addr[UNIT_MEM]  = sb.write_addr_mem;
        wb_addr[UNIT_FPU]  = sb.write_addr_fpu;
    end

    assign int_clr_en = wb_en & ~wb_flt;
    assign flt_clr_en = wb_en &  wb_flt;
    assign int_set_en = fire_c & sb.dest_valid & ~sb.dest_float;
    assign flt_set_en = fire_c & sb.dest_valid &  sb.dest_float;

    issue_scoreboard_busy_table #(.ZERO_R0(1'b1)) u_int_table (
        .clk         (clk),
        .reset       (reset),
        .set_en_i    (int_set_en),
        .set_addr_i  (sb.dest_addr),
        .clr_en_i    (int_clr_en),
        .clr_addr_i  (wb_addr),
        .rd_addr_a_i (sb.rs_addr),
        .rd_addr_b_i (sb.rt_addr),
        .rd_busy_a_o (int_rd_rs),
        .rd_busy_b_o (int_rd_rt),
        .view_o      (int_view),
        .busy_d_o    (int_busy_d)
    );

    issue_scoreboard_busy_table #(.ZERO_R0(1'b0)) u_flt_table (
        .clk         (clk),
        .reset       (reset),
        .set_en_i    (flt_set_en),
        .set_addr_i  (sb.dest_addr),
        .clr_en_i    (flt_clr_en),
        .clr_addr_i  (wb_addr),
        .rd_addr_a_i (sb.rs_addr),
        .rd_addr_b_i (sb.rt_addr),
        .rd_busy_a_o (flt_rd_rs),
        .rd_busy_b_o (flt_rd_rt),
        .view_o      (flt_view),
        .busy_d_o    (flt_busy_d)
    );

    // Hazard detection against the selected register file
    always_comb begin
        rs_hazard   = sb.rs_used & (sb.rs_float ? flt_rd_rs : int_rd_rs);
        rt_hazard   = sb.rt_used & (sb.rt_float ? flt_rd_rt : int_rd_rt);
        dest_hazard = sb.dest_valid &
                      (sb.dest_float ? flt_view[sb.dest_addr] : int_view[sb.dest_addr]);
        stall_c     = sb.issue_valid & (rs_hazard | rt_hazard | dest_hazard);
        fire_c      = sb.issue_valid & ~stall_c;
    end

    // Occupancy from next-state vectors and saturating stall counter
    always_comb begin
        busy_count_d = BUSY_CNT_W'(popcount_vec(int_busy_d)) +
                       BUSY_CNT_W'(popcount_vec(flt_busy_d));
        idle_d       = (busy_count_d == '0);
        stall_cnt_d  = stall_cnt_q;
        if (stall_c && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_count_q <= '0;
            idle_q       <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            busy_count_q <= busy_count_d;
            idle_q       <= idle_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign sb.stall        = stall_c;
    assign sb.issue_fire   = fire_c;
    assign sb.busy_count   = busy_count_q;
    assign sb.idle         = idle_q;
    assign sb.stall_cycles = stall_cnt_q;

endmodule
